// File: rtl/widths_concat_pkg.sv
// Shared types and field positions for the 18-bit concat/replication frame.
// Frame layout, MSB first: {pad[1:0], a[3:0], b[1:0], rep_a[3:0], rep_b[5:0]}.
package widths_concat_pkg;

    localparam int A_W     = 4;
    localparam int B_W     = 2;
    localparam int BEAT_W  = 6;
    localparam int FRAME_W = 18;

    localparam int PAD_MSB  = 17;
    localparam int PAD_LSB  = 16;
    localparam int A_MSB    = 15;
    localparam int A_LSB    = 12;
    localparam int B_MSB    = 11;
    localparam int B_LSB    = 10;
    localparam int REPA_MSB = 9;
    localparam int REPA_LSB = 6;
    localparam int REPB_MSB = 5;
    localparam int REPB_LSB = 0;

    typedef struct packed {
        logic [1:0]     pad;
        logic [A_W-1:0] a;
        logic [B_W-1:0] b;
        logic [A_W-1:0] rep_a;
        logic [5:0]     rep_b;
    } frame_t;

    // Named for the beat the assembler expects next.
    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2
    } state_t;

endpackage

// File: rtl/widths_concat_repl_check.sv
// Combinational field recovery and padding/replica checks for one frame.
// err_o = {pad_err, rep_a_err, rep_b_err}.
module widths_concat_repl_check
    import widths_concat_pkg::*;
(
    input  frame_t         frame_i,
    output logic [A_W-1:0] a_o,
    output logic [B_W-1:0] b_o,
    output logic [2:0]     err_o
);

    logic pad_err;
    logic rep_a_err;
    logic rep_b_err;

    assign a_o = frame_i.a;
    assign b_o = frame_i.b;

    assign pad_err   = |frame_i.pad;
    assign rep_a_err = frame_i.rep_a != frame_i.a;
    assign rep_b_err = (frame_i.rep_b[5:4] != frame_i.b)
                     | (frame_i.rep_b[3:2] != frame_i.b)
                     | (frame_i.rep_b[1:0] != frame_i.b);

    assign err_o = {pad_err, rep_a_err, rep_b_err};

endmodule

// File: rtl/widths_concat_repl_decoder.sv
// Three-beat frame assembler with registered valid/ready output.
// Optional saturating bad-frame counter: WIDTHS_CONCAT_REPL_DECODER_ERRCNT_EN.
module widths_concat_repl_decoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sop,
    input  logic [5:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_a,
    output logic [1:0]       out_b,
    output logic [2:0]       out_err,
`ifdef WIDTHS_CONCAT_REPL_DECODER_ERRCNT_EN
    output logic [CNT_W-1:0] err_cnt,
`endif
    output logic             frm_err
);

    import widths_concat_pkg::*;

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat0_q, beat0_d;
    logic [BEAT_W-1:0]   beat1_q, beat1_d;
    logic                frm_err_d;
    logic                load;
    logic                accept;

    logic                out_valid_q;
    logic [A_W-1:0]      out_a_q;
    logic [B_W-1:0]      out_b_q;
    logic [2:0]          out_err_q;
    logic                frm_err_q;

    frame_t              frame;
    logic [A_W-1:0]      chk_a;
    logic [B_W-1:0]      chk_b;
    logic [2:0]          chk_err;

    assign frame = frame_t'({beat0_q, beat1_q, in_data});

    widths_concat_repl_check u_check (
        .frame_i (frame),
        .a_o     (chk_a),
        .b_o     (chk_b),
        .err_o   (chk_err)
    );

    // Final beat may only land when the output slot is free or draining.
    assign in_ready = (state_q != S2) || !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        beat0_d   = beat0_q;
        beat1_d   = beat1_q;
        frm_err_d = 1'b0;
        load      = 1'b0;
        if (accept) begin
            if (in_sop) begin
                beat0_d   = in_data;
                state_d   = S1;
                frm_err_d = (state_q != S0);
            end else begin
                unique case (state_q)
                    S0: frm_err_d = 1'b1;
                    S1: begin
                        beat1_d = in_data;
                        state_d = S2;
                    end
                    S2: begin
                        load    = 1'b1;
                        state_d = S0;
                    end
                    default: state_d = S0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S0;
            beat0_q   <= '0;
            beat1_q   <= '0;
            frm_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat0_q   <= beat0_d;
            beat1_q   <= beat1_d;
            frm_err_q <= frm_err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_err_q   <= '0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            out_a_q     <= chk_a;
            out_b_q     <= chk_b;
            out_err_q   <= chk_err;
        end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

`ifdef WIDTHS_CONCAT_REPL_DECODER_ERRCNT_EN
    logic [CNT_W-1:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (load && (|chk_err) && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_q <= err_cnt_q + CNT_W'(1);
        end
    end

    assign err_cnt = err_cnt_q;
`endif

    assign out_valid = out_valid_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_err   = out_err_q;
    assign frm_err   = frm_err_q;

endmodule

// File: tb/tb_widths_concat_repl_decoder.sv
// Directed-vector bench; expected frames go to a queue, a monitor pops them
// on each output handshake.
module tb_widths_concat_repl_decoder;

    localparam int CW = 2;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          in_sop;
    logic [5:0]    in_data;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    out_a;
    logic [1:0]    out_b;
    logic [2:0]    out_err;
    logic          frm_err;
`ifdef WIDTHS_CONCAT_REPL_DECODER_ERRCNT_EN
    logic [CW-1:0] err_cnt;
`endif

    int n_vec = 0;
    int n_bad = 0;
    logic [8:0] exp_q[$];

    widths_concat_repl_decoder #(.CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sop    (in_sop),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_err   (out_err),
`ifdef WIDTHS_CONCAT_REPL_DECODER_ERRCNT_EN
        .err_cnt   (err_cnt),
`endif
        .frm_err   (frm_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: a handshake is sampled mid-cycle, before the edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_frame: got a=%0h b=%0h err=%0b, want none",
                         out_a, out_b, out_err);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                if ({out_a, out_b, out_err} !== e) begin
                    n_bad++;
                    $display("FAIL frame: got a=%0h b=%0h err=%0b, want a=%0h b=%0h err=%0b",
                             out_a, out_b, out_err, e[8:5], e[4:3], e[2:0]);
                end
            end
        end
    end

    task automatic send(input logic [5:0] d, input logic s);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_sop   = s;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) chk("beat_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
    endtask

    task automatic frame(input logic [5:0] b0, input logic [5:0] b1,
                         input logic [5:0] b2, input logic [3:0] ea,
                         input logic [1:0] eb, input logic [2:0] ee);
        send(b0, 1'b1);
        send(b1, 1'b0);
        exp_q.push_back({ea, eb, ee});
        send(b2, 1'b0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 100) begin
            n++;
            @(posedge clk);
            #1;
        end
        chk("drain_queue", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_outs", {23'd0, out_a, out_b, out_err}, 32'd0);
        chk("rst_frm_err", 32'(frm_err), 32'd0);
`ifdef WIDTHS_CONCAT_REPL_DECODER_ERRCNT_EN
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sop    = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        #12;
        chk_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Clean frame, one-cycle latency
        exp_q.push_back({4'hA, 2'b01, 3'b000});
        send(6'h0A, 1'b1);
        send(6'h1A, 1'b0);
        send(6'h15, 1'b0);
        chk("latency_valid", 32'(out_valid), 32'd1);
        drain();

        // Corrupt frames
        frame(6'h0A, 6'h1A, 6'h14, 4'hA, 2'b01, 3'b001);
        frame(6'h3A, 6'h1A, 6'h15, 4'hA, 2'b01, 3'b100);
        drain();
`ifdef WIDTHS_CONCAT_REPL_DECODER_ERRCNT_EN
        chk("err_cnt_two", 32'(err_cnt), 32'd2);
`endif

        // Backpressure
        out_ready = 1'b0;
        frame(6'h05, 6'h25, 6'h2A, 4'h5, 2'b10, 3'b000);
        send(6'h03, 1'b1);
        send(6'h33, 1'b0);
        exp_q.push_back({4'h3, 2'b11, 3'b000});
        in_valid = 1'b1;
        in_data  = 6'h3F;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_hold", {23'd0, out_valid, out_a, out_b, out_err},
                {23'd0, 1'b1, 4'h5, 2'b10, 3'b000});
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_reload", {26'd0, out_valid, out_a, out_b[0]},
            {26'd0, 1'b1, 4'h3, 1'b1});
        drain();

        // Framing errors
        send(6'h0A, 1'b1);
        send(6'h05, 1'b1);
        chk("frm_err_pulse", 32'(frm_err), 32'd1);
        send(6'h05, 1'b0);
        chk("frm_err_clear", 32'(frm_err), 32'd0);
        exp_q.push_back({4'h5, 2'b00, 3'b000});
        send(6'h00, 1'b0);
        drain();
        send(6'h2A, 1'b0);
        chk("frm_err_s0", 32'(frm_err), 32'd1);
        frame(6'h0A, 6'h1A, 6'h15, 4'hA, 2'b01, 3'b000);
        drain();

        // Reset with held output and a partial frame
        out_ready = 1'b0;
        frame(6'h05, 6'h25, 6'h2A, 4'h5, 2'b10, 3'b000);
        send(6'h0A, 1'b1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk_reset_vals();
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        frame(6'h03, 6'h33, 6'h3F, 4'h3, 2'b11, 3'b000);
        drain();
        chk("post_rst_frm_err", 32'(frm_err), 32'd0);

        // Counter saturation
        for (int i = 0; i < 5; i++)
            frame(6'h0A, 6'h1A, 6'h14, 4'hA, 2'b01, 3'b001);
        drain();
`ifdef WIDTHS_CONCAT_REPL_DECODER_ERRCNT_EN
        chk("err_cnt_sat", 32'(err_cnt), 32'd3);
`endif

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/widths_concat_repl_decoder.md
# widths_concat_repl_decoder

Receive-side decoder for the 18-bit concat/replication frame. It assembles a frame from three 6-bit beats and checks the padding and the replicated copies. It then recovers the 4-bit `a` and 2-bit `b` fields and presents them on a registered valid/ready output. It sits at the far end of the frame link, opposite the packer that builds `{cat_ab, rep_a, rep_b}`.

## Interface
Parameters:
- `CNT_W`, default 8: width of the saturating error counter.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  a beat is present on `in_data`.
- `in_ready`  out  1  the decoder accepts the beat this cycle.
- `in_sop`  in  1  the current beat is beat 0 of a frame.
- `in_data`  in  6  beat payload; beat 0 carries frame[17:12], beat 1 frame[11:6], beat 2 frame[5:0].
- `out_valid`  out  1  a decoded frame is held.
- `out_ready`  in  1  the consumer takes the frame.
- `out_a`  out  4  recovered `a`.
- `out_b`  out  2  recovered `b`.
- `out_err`  out  3  {pad_err, rep_a_err, rep_b_err} for the held frame.
- `frm_err`  out  1  one-cycle pulse on a framing error.
- `err_cnt`  out  CNT_W  saturating count of bad frames. Present only with the macro defined.

## Operation
- Frame format (decided):
  - frame[17:10] = {2'b00, a, b}.
  - frame[9:6] = a.
  - frame[5:0] = {b, b, b}.
- Recovery: `a` = frame[15:12] and `b` = frame[11:10], both taken from the cat field.
- Checks on every frame:
  - pad_err = frame[17:16] != 0.
  - rep_a_err = frame[9:6] != frame[15:12].
  - rep_b_err = any 2-bit slice of frame[5:0] != frame[11:10].
- A frame with errors is still delivered, with `out_err` set. It is never dropped.
- Assembler FSM has states S0, S1, S2 (the beat expected next).
  - S0: a beat with `in_sop`=1 is stored in frame[17:12] and the FSM goes to S1. A beat with `in_sop`=0 is discarded, `frm_err` pulses and the FSM stays in S0.
  - S1: a beat with `in_sop`=0 goes to frame[11:6] and the FSM goes to S2.
  - S2: a beat with `in_sop`=0 goes to frame[5:0], the frame is decoded into the output register and the FSM returns to S0.
  - In S1 or S2, a beat with `in_sop`=1 abandons the partial frame and pulses `frm_err`. That beat is taken as beat 0 of a new frame and the FSM goes to S1.
- `in_ready` = 1 in S0 and S1. In S2, `in_ready` = !out_valid || out_ready, so the final beat can complete only when the output slot is free or draining that cycle.
- Output register:
  - Loaded on final-beat acceptance.
  - Cleared when `out_valid && out_ready` and no new load occurs.
  - A load and a drain in the same cycle leave `out_valid` = 1 holding the new frame.

## Timing
- Reset values:
  - FSM in S0.
  - `in_ready` = 1.
  - `out_valid` = 0.
  - `out_a` = 0, `out_b` = 0, `out_err` = 0.
  - `frm_err` = 0.
  - `err_cnt` = 0.
- Reset asserted mid-frame discards the partial frame and any held output with no pulse.
- Latency: `out_valid` rises the cycle after the beat-2 handshake.
- Peak throughput is one frame per 3 cycles with `out_ready` held at 1. There are no bubbles.
- `out_a`, `out_b` and `out_err` are stable while `out_valid && !out_ready`.
- `frm_err` is registered and asserts the cycle after the offending beat.

## Configuration
- Macro: `WIDTHS_CONCAT_REPL_DECODER_ERRCNT_EN`.
- Defined:
  - `err_cnt` port exists.
  - It increments by 1 on each output load with `out_err` != 0.
  - It saturates at 2^CNT_W-1.
  - Framing errors are not counted.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Package `widths_concat_pkg` holds:
  - `A_W`=4, `B_W`=2, `BEAT_W`=6, `FRAME_W`=18.
  - Field-position localparams.
  - The `frame_t` packed struct {pad, a, b, rep_a, rep_b}.
  - The FSM state enum.
- One sub-module, `widths_concat_repl_check`: purely combinational, takes `frame_t` and returns a, b and the 3-bit error vector. The top holds the FSM, the beat registers and the output register.

## Test plan
- Clean frame a=4'hA, b=2'b01: beats 6'h0A, 6'h1A (frame[11:6]={b,a}), 6'h15 with `out_ready`=1. Expect `out_valid` one cycle after beat 2, `out_a`=A, `out_b`=1, `out_err`=0.
- Corrupt frame: rep_b slice flipped to 6'h14, then pad bits set on a second frame. Expect `out_err`=3'b001, then 3'b100, and `err_cnt`=2 with the macro defined.
- Backpressure: `out_ready`=0 while a second frame arrives. Expect `in_ready`=0 in S2 and the held outputs stable. Raising `out_ready` completes beat 2 in that same cycle and `out_valid` stays 1 with the second frame.
- Framing: `in_sop`=1 on the second beat. Expect a `frm_err` pulse, the first frame never emitted, and the next two beats completing the new frame. A non-sop beat in S0 also pulses `frm_err` and is discarded.
- Reset mid-frame and while `out_valid`=1: expect all outputs at reset values, and a clean frame afterwards decodes normally.
- Counter saturation with CNT_W=2: five bad frames leave `err_cnt`=3.
